// File: rtl/program_loader.sv
// Byte-stream bootloader: decodes framed program images into instruction-memory writes and gates cpu_en.
// Optional inter-byte frame timeout is compiled in with `define LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int ADDR_W         = 11,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       w_instruction,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              busy,
  output logic              err,
  output logic              done
);

  localparam logic [7:0] CMD_START = 8'hA5;
  localparam logic [7:0] CMD_RUN   = 8'h5A;
  localparam logic [7:0] CMD_HALT  = 8'hC3;

  // Address is assembled from a 16-bit header, so widths above 16 are not representable.
  if (ADDR_W < 1 || ADDR_W > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("program_loader: ADDR_W must be 1..16 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHKSUM
  } state_t;

  state_t            state, state_n;
  logic              accept;
  logic [7:0]        addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        words_left;
  logic [1:0]        byte_idx;
  logic [23:0]       shift_q;
  logic [7:0]        csum;
  logic              timeout;

  assign accept = in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              in_frame;

  assign in_frame = (state != S_IDLE) && (state != S_WRITE);
  assign timeout  = in_frame && !accept && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (!in_frame || accept || timeout)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = (state != S_WRITE);
    w_enable = (state == S_WRITE);
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE:    if (accept && in_data == CMD_START) state_n = S_ADDR_HI;
      S_ADDR_HI: if (accept) state_n = S_ADDR_LO;
      S_ADDR_LO: if (accept) state_n = S_COUNT;
      S_COUNT:   if (accept) state_n = S_DATA;
      S_DATA:    if (accept && byte_idx == 2'd3) state_n = S_WRITE;
      S_WRITE:   state_n = (words_left == 9'd1) ? S_CHKSUM : S_DATA;
      S_CHKSUM:  if (accept) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (timeout)
      state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hi_q     <= '0;
      addr_q        <= '0;
      words_left    <= '0;
      byte_idx      <= '0;
      shift_q       <= '0;
      csum          <= '0;
      w_instruction <= '0;
      w_adrs        <= '0;
      cpu_en        <= 1'b0;
      err           <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_START: begin
                cpu_en <= 1'b0;
                err    <= 1'b0;
                csum   <= '0;
              end
              CMD_RUN:  if (!err) cpu_en <= 1'b1;
              CMD_HALT: cpu_en <= 1'b0;
              default:  ;
            endcase
          end
        end
        S_ADDR_HI: begin
          if (accept) begin
            addr_hi_q <= in_data;
            csum      <= csum ^ in_data;
          end
        end
        S_ADDR_LO: begin
          if (accept) begin
            addr_q <= ADDR_W'({addr_hi_q, in_data});
            csum   <= csum ^ in_data;
          end
        end
        S_COUNT: begin
          if (accept) begin
            words_left <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            byte_idx   <= '0;
            csum       <= csum ^ in_data;
          end
        end
        S_DATA: begin
          if (accept) begin
            shift_q  <= {shift_q[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            csum     <= csum ^ in_data;
            // Latch the write port at the 4th byte so it is valid in WRITE and held afterwards.
            if (byte_idx == 2'd3) begin
              w_instruction <= {shift_q, in_data};
              w_adrs        <= addr_q;
            end
          end
        end
        S_WRITE: begin
          addr_q     <= addr_q + 1'b1;
          words_left <= words_left - 9'd1;
        end
        S_CHKSUM: begin
          if (accept) begin
            if (in_data != csum) err <= 1'b1;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (timeout) begin
        err  <= 1'b1;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader; timeout scenario runs when LOADER_TIMEOUT_EN is defined.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] w_instruction;
  logic        w_enable;
  logic [10:0] w_adrs;
  logic        cpu_en;
  logic        busy;
  logic        err;
  logic        done;

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_W        (11),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .w_instruction(w_instruction),
    .w_enable     (w_enable),
    .w_adrs       (w_adrs),
    .cpu_en       (cpu_en),
    .busy         (busy),
    .err          (err),
    .done         (done)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [10:0] wq_adrs[$];
  logic [31:0] wq_data[$];
  int          stall_cnt = 0;
  int          done_cnt  = 0;
  logic [7:0]  fq[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (w_enable) begin
        wq_adrs.push_back(w_adrs);
        wq_data.push_back(w_instruction);
      end
      if (in_valid && !in_ready) stall_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leaves in_valid high so back-to-back calls present a continuous stream.
  task automatic send(input logic [7:0] b);
    int   waited;
    logic took;
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      took = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!took && waited < 50);
    if (!took) check_eq("send_bound", {31'b0, took}, 32'd1);
  endtask

  task automatic send_frame();
    foreach (fq[i]) send(fq[i]);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic good_frame();
    fq = {8'hA5, 8'h00, 8'h01, 8'h01, 8'hE0, 8'h00, 8'h03, 8'h0F, 8'hEC};
  endtask

  int base_w;
  int base_s;
  int base_d;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cpu_en", cpu_en, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_w_enable", w_enable, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Good load, then run
    base_w = wq_adrs.size();
    base_d = done_cnt;
    good_frame();
    send_frame();
    check_eq("good_done", done, 1);
    check_eq("good_busy", busy, 0);
    check_eq("good_err", err, 0);
    check_eq("good_cpu_en", cpu_en, 0);
    check_eq("good_nwr", wq_adrs.size() - base_w, 1);
    check_eq("good_adrs", wq_adrs[base_w], 11'h001);
    check_eq("good_data", wq_data[base_w], 32'hE000030F);
    idle_cycle();
    check_eq("good_done_pulse", done, 0);
    check_eq("good_done_cnt", done_cnt - base_d, 1);
    check_eq("good_hold_data", w_instruction, 32'hE000030F);
    send(8'h5A);
    in_valid = 1'b0;
    check_eq("run_cpu_en", cpu_en, 1);

    // Address wrap with per-word latency
    base_w = wq_adrs.size();
    send(8'hA5);
    check_eq("wrap_start_cpu_en", cpu_en, 0);
    send(8'h07); send(8'hFF); send(8'h02);
    send(8'hFF); send(8'hFF); send(8'h00);
    check_eq("wrap_pre_wen", w_enable, 0);
    send(8'h00);
    check_eq("wrap_w0_wen", w_enable, 1);
    check_eq("wrap_w0_adrs", w_adrs, 11'h7FF);
    check_eq("wrap_w0_data", w_instruction, 32'hFFFF0000);
    check_eq("wrap_w0_ready", in_ready, 0);
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'hAA);
    check_eq("wrap_w1_wen", w_enable, 1);
    check_eq("wrap_w1_adrs", w_adrs, 11'h000);
    check_eq("wrap_w1_data", w_instruction, 32'hAAAAAAAA);
    send(8'hFA);
    in_valid = 1'b0;
    check_eq("wrap_done", done, 1);
    check_eq("wrap_err", err, 0);
    check_eq("wrap_nwr", wq_adrs.size() - base_w, 2);

    // Checksum error blocks run until a clean frame
    fq = {8'hA5, 8'h00, 8'h01, 8'h01, 8'hE0, 8'h00, 8'h03, 8'h0F, 8'h00};
    send_frame();
    check_eq("bad_done", done, 1);
    check_eq("bad_err", err, 1);
    send(8'h5A);
    in_valid = 1'b0;
    check_eq("bad_run_cpu_en", cpu_en, 0);
    check_eq("bad_err_sticky", err, 1);
    good_frame();
    send_frame();
    check_eq("recover_err", err, 0);
    send(8'h5A);
    in_valid = 1'b0;
    check_eq("recover_cpu_en", cpu_en, 1);

    // Continuous in_valid through a 3-word frame; command codes inside are data
    base_w = wq_adrs.size();
    base_s = stall_cnt;
    fq = {8'hA5, 8'h01, 8'h23, 8'h03,
          8'h11, 8'h22, 8'h33, 8'h44,
          8'hA5, 8'hA5, 8'hA5, 8'hA5,
          8'h5A, 8'hC3, 8'h00, 8'h5A,
          8'hA6};
    send_frame();
    check_eq("bp_cpu_en", cpu_en, 0);
    check_eq("bp_err", err, 0);
    check_eq("bp_stalls", stall_cnt - base_s, 3);
    check_eq("bp_nwr", wq_adrs.size() - base_w, 3);
    check_eq("bp_adrs0", wq_adrs[base_w], 11'h123);
    check_eq("bp_data0", wq_data[base_w], 32'h11223344);
    check_eq("bp_adrs1", wq_adrs[base_w + 1], 11'h124);
    check_eq("bp_data1", wq_data[base_w + 1], 32'hA5A5A5A5);
    check_eq("bp_adrs2", wq_adrs[base_w + 2], 11'h125);
    check_eq("bp_data2", wq_data[base_w + 2], 32'h5AC3005A);
    send(8'h5A);
    in_valid = 1'b0;
    check_eq("halt_pre_cpu_en", cpu_en, 1);
    send(8'hC3);
    in_valid = 1'b0;
    check_eq("halt_cpu_en", cpu_en, 0);

    // Asynchronous reset mid-frame
    send(8'h5A);
    base_w = wq_adrs.size();
    send(8'hA5); send(8'h00); send(8'h10); send(8'h01);
    send(8'hAA); send(8'hBB);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_cpu_en", cpu_en, 0);
    check_eq("mid_rst_w_enable", w_enable, 0);
    check_eq("mid_rst_w_adrs", w_adrs, 0);
    check_eq("mid_rst_w_data", w_instruction, 0);
    check_eq("mid_rst_err", err, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_nwr", wq_adrs.size() - base_w, 0);
    good_frame();
    send_frame();
    check_eq("post_rst_err", err, 0);
    check_eq("post_rst_nwr", wq_adrs.size() - base_w, 1);
    check_eq("post_rst_adrs", wq_adrs[base_w], 11'h001);
    check_eq("post_rst_data", wq_data[base_w], 32'hE000030F);

`ifdef LOADER_TIMEOUT_EN
    base_w = wq_adrs.size();
    send(8'hA5);
    send(8'h00);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_eq("to_busy_before", busy, 1);
    check_eq("to_err_before", err, 0);
    @(posedge clk);
    #1;
    check_eq("to_err", err, 1);
    check_eq("to_done", done, 1);
    check_eq("to_busy", busy, 0);
    check_eq("to_cpu_en", cpu_en, 0);
    check_eq("to_nwr", wq_adrs.size() - base_w, 0);
`endif

    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream bootloader that sits directly upstream of the pipelined CPU top level.
- Receives framed program images over a valid/ready byte interface.
- Drives the CPU instruction-memory write port (w_instruction, w_enable, w_adrs) one 32-bit word at a time.
- Gates cpu_en: the CPU is held stopped while loading and released only by an explicit run command after a clean load.

Parameters:
- ADDR_W, 11, instruction-memory address width; matches the w_adrs width.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes inside a frame. Used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle. A byte transfers when in_valid && in_ready.
- w_instruction  output  32  word to write into instruction memory.
- w_enable  output  1  one-cycle write strobe.
- w_adrs  output  ADDR_W  write address.
- cpu_en  output  1  CPU run enable.
- busy  output  1  high whenever state != IDLE.
- err  output  1  sticky frame error flag.
- done  output  1  one-cycle pulse at end of every frame, good or bad.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except in_ready=1. cpu_en=0; err=0; internal address, count, checksum and byte index cleared. Reset mid-frame aborts the frame; writes already issued are not undone.
- IDLE command bytes:
  - 0xA5: start frame. cpu_en->0 and err->0 on the accept edge; checksum cleared; go to ADDR_HI.
  - 0x5A: run. cpu_en->1 next cycle, only if err=0; otherwise ignored.
  - 0xC3: halt. cpu_en->0.
  - Any other byte: accepted and discarded.
- Frame states:
  - ADDR_HI: bits[2:0] become address[10:8]; bits[7:3] are ignored for addressing but still enter the checksum.
  - ADDR_LO: becomes address[7:0].
  - COUNT: number of words to load; 0 means 256.
  - DATA: four bytes, big-endian (first byte = word[31:24]). After the 4th byte is accepted, go to WRITE.
  - WRITE: exactly one cycle. w_enable=1 with w_instruction and w_adrs valid; in_ready=0. Then address increments mod 2^ADDR_W (0x7FF -> 0x000) and the remaining-word count decrements. Go to DATA if words remain, otherwise CHKSUM.
  - CHKSUM: received byte is compared with the running XOR of every byte after the header (addr_hi, addr_lo, count, all data bytes). Mismatch -> err=1. done pulses the cycle after acceptance; return to IDLE.
- Latency: the write strobe occurs exactly 1 cycle after the 4th data byte is accepted.
- w_instruction and w_adrs hold their last values when w_enable=0.
- in_ready=1 in every state except WRITE. Bytes presented during WRITE are stalled and must not be lost.
- Loading never sets cpu_en. A frame always leaves cpu_en=0 until a later 0x5A.
- 0xA5 / 0x5A / 0xC3 received inside a frame are treated as data, not commands.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: an idle counter runs in ADDR_HI..CHKSUM (WRITE excluded). It resets on every accepted byte. If it reaches TIMEOUT_CYCLES: err=1, done pulses, return to IDLE, cpu_en stays 0.
- Undefined: no counter; the loader waits indefinitely inside a frame.

Test Plan:
- Good load: A5 00 01 01 E0 00 03 0F EC -> one w_enable pulse with w_adrs=0x001, w_instruction=0xE000030F; err=0; done pulse; cpu_en=0. Then 5A -> cpu_en=1.
- Wrap: A5 07 FF 02, words 0xFFFF0000 and 0xAAAAAAAA, correct checksum -> writes at 0x7FF then 0x000, each exactly 1 cycle after its 4th byte.
- Checksum error: good load frame with final byte EC replaced by 00 -> err=1; following 5A leaves cpu_en=0; a new good frame clears err; then 5A -> cpu_en=1.
- Backpressure/halt: in_valid held high continuously through a 3-word frame -> in_ready=0 only in the 3 WRITE cycles; all bytes land correctly. With cpu_en=1, sending C3 -> cpu_en=0.
- Reset mid-frame: assert reset after the 2nd data byte -> outputs are at reset values immediately (no clock edge needed); after release, a fresh good frame loads normally.
- Timeout (LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): A5 00 then silence for 16 cycles -> err=1, done pulse, busy=0, no w_enable.
